// File: rtl/inst_fetch.sv
// Instruction-fetch stage: issues req/ack fetches for pc_i, buffers one word while
// IF/ID is held, retries after a bus timeout, and drives the IF/ID pipeline register.
module inst_fetch #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic [5:0]        stall,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stallreq_o,
    output logic              fetch_err_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_inst_o
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, RETRY} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
    logic [DATA_W-1:0] buf_inst_q, buf_inst_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [DATA_W-1:0] id_inst_q, id_inst_d;
    logic              err_q, err_d;

    logic fetching;
    logic accept;
    logic timeout;
    logic unused_stall;

    // An ack only counts while a request is actually on the bus.
    assign fetching     = (state_q == FETCH) && ce_i;
    assign accept       = fetching && mem_ack_i;
    assign timeout      = fetching && !mem_ack_i && (cnt_q == TMO_LAST);
    assign unused_stall = ^{stall[5:3], stall[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!ce_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = FETCH;
                FETCH: begin
                    if (mem_ack_i) begin
                        state_d = stall[1] ? HOLD : FETCH;
                    end else if (timeout) begin
                        state_d = RETRY;
                    end
                end
                RETRY: state_d = FETCH;
                HOLD:  if (!stall[1]) state_d = FETCH;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req_o   = fetching;
        mem_addr_o  = fetching ? pc_i : '0;
        stallreq_o  = (fetching && !mem_ack_i) || ((state_q == RETRY) && ce_i);
        fetch_err_o = err_q;
        id_pc_o     = id_pc_q;
        id_inst_o   = id_inst_q;
    end

    always_comb begin
        cnt_d      = (fetching && !mem_ack_i && !timeout) ? cnt_q + 16'd1 : 16'd0;
        err_d      = timeout;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        // Default IF/ID behaviour: hold when ID is also stalled, otherwise bubble.
        if (stall[1] && stall[2]) begin
            id_pc_d   = id_pc_q;
            id_inst_d = id_inst_q;
        end else begin
            id_pc_d   = '0;
            id_inst_d = '0;
        end

        if (!ce_i) begin
            buf_pc_d   = '0;
            buf_inst_d = '0;
            id_pc_d    = '0;
            id_inst_d  = '0;
        end else if (accept && !stall[1]) begin
            id_pc_d   = pc_i;
            id_inst_d = mem_rdata_i;
        end else if (accept) begin
            buf_pc_d   = pc_i;
            buf_inst_d = mem_rdata_i;
        end else if ((state_q == HOLD) && !stall[1]) begin
            id_pc_d    = buf_pc_q;
            id_inst_d  = buf_inst_q;
            buf_pc_d   = '0;
            buf_inst_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            err_q      <= 1'b0;
            buf_pc_q   <= '0;
            buf_inst_q <= '0;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
        end
    end

endmodule
